// File: rtl/controlador_hamming.sv
// ============================================================================
// Module   : controlador_hamming
// Summary  : Button-sequenced capture, SECDED (8,4) syndrome evaluation and
//            timed result display for the Hamming lab datapath.
//            Optional macro CORRECCION_EN enables single-error data correction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_hamming #(
  parameter int T_MUESTRA = 50_000_000,
  parameter int N_SYNC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] conmutador_4,
  input  logic [7:0] conmutador_8,
  input  logic       btn_cargar,
  input  logic       btn_evaluar,
  output logic [3:0] palabra_ref,
  output logic [3:0] sindrome,
  output logic [1:0] tipo_error,
  output logic [3:0] dato_corregido,
  output logic       coincide,
  output logic       resultado_valido,
  output logic       mostrando
);

  localparam int CW = $clog2(T_MUESTRA + 1);

  typedef enum logic [1:0] {
    ESPERA_REF = 2'd0,
    ESPERA_RX  = 2'd1,
    EVALUA     = 2'd2,
    MUESTRA    = 2'd3
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [N_SYNC-1:0] sync_cargar_q, sync_cargar_d;
  logic [N_SYNC-1:0] sync_evaluar_q, sync_evaluar_d;
  logic              prev_cargar_q, prev_evaluar_q;
  logic              p_cargar, p_evaluar;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [3:0]        palabra_ref_q, palabra_ref_d;
  logic [3:0]        sindrome_q, sindrome_d;
  logic [1:0]        tipo_error_q, tipo_error_d;
  logic [3:0]        dato_q, dato_d;
  logic              coincide_q, coincide_d;
  logic              valido_q, valido_d;
  logic              mostrando_q, mostrando_d;

  logic [2:0]        s;
  logic              gp;
  logic [1:0]        tipo_calc;
  logic [3:0]        dato_calc;

  assign sync_cargar_d  = {sync_cargar_q[N_SYNC-2:0], btn_cargar};
  assign sync_evaluar_d = {sync_evaluar_q[N_SYNC-2:0], btn_evaluar};
  assign p_cargar       = sync_cargar_q[N_SYNC-1] & ~prev_cargar_q;
  assign p_evaluar      = sync_evaluar_q[N_SYNC-1] & ~prev_evaluar_q;

  // Bit index i of rx is Hamming position i+1; g0 (bit7) is the overall parity.
  always_comb begin
    s[0] = rx_q[0] ^ rx_q[2] ^ rx_q[4] ^ rx_q[6];
    s[1] = rx_q[1] ^ rx_q[2] ^ rx_q[5] ^ rx_q[6];
    s[2] = rx_q[3] ^ rx_q[4] ^ rx_q[5] ^ rx_q[6];
    gp   = ^rx_q;
    if (gp)
      tipo_calc = 2'b01;
    else if (s != 3'd0)
      tipo_calc = 2'b10;
    else
      tipo_calc = 2'b00;
`ifdef CORRECCION_EN
    dato_calc = {rx_q[2] ^ (gp && s == 3'd3),
                 rx_q[4] ^ (gp && s == 3'd5),
                 rx_q[5] ^ (gp && s == 3'd6),
                 rx_q[6] ^ (gp && s == 3'd7)};
`else
    dato_calc = {rx_q[2], rx_q[4], rx_q[5], rx_q[6]};
`endif
  end

  // Priority in every state: cargar, then evaluar, then hold timeout.
  always_comb begin
    estado_d      = estado_q;
    cnt_d         = cnt_q;
    rx_d          = rx_q;
    palabra_ref_d = palabra_ref_q;
    sindrome_d    = sindrome_q;
    tipo_error_d  = tipo_error_q;
    dato_d        = dato_q;
    coincide_d    = coincide_q;
    valido_d      = 1'b0;
    case (estado_q)
      ESPERA_REF: begin
        if (p_cargar) begin
          palabra_ref_d = conmutador_4;
          estado_d      = ESPERA_RX;
        end
      end
      ESPERA_RX: begin
        if (p_cargar) begin
          palabra_ref_d = conmutador_4;
        end else if (p_evaluar) begin
          rx_d     = conmutador_8;
          estado_d = EVALUA;
        end
      end
      EVALUA: begin
        sindrome_d   = {gp, s};
        tipo_error_d = tipo_calc;
        dato_d       = dato_calc;
        coincide_d   = (dato_calc == palabra_ref_q);
        valido_d     = 1'b1;
        cnt_d        = '0;
        estado_d     = MUESTRA;
      end
      MUESTRA: begin
        if (p_cargar) begin
          palabra_ref_d = conmutador_4;
          sindrome_d    = '0;
          tipo_error_d  = '0;
          dato_d        = '0;
          coincide_d    = 1'b0;
          estado_d      = ESPERA_RX;
        end else if (p_evaluar) begin
          rx_d     = conmutador_8;
          estado_d = EVALUA;
        end else if (cnt_q == CW'(T_MUESTRA - 1)) begin
          estado_d = ESPERA_RX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = ESPERA_REF;
    endcase
    mostrando_d = (estado_d == MUESTRA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= ESPERA_REF;
      sync_cargar_q  <= '0;
      sync_evaluar_q <= '0;
      prev_cargar_q  <= 1'b0;
      prev_evaluar_q <= 1'b0;
      cnt_q          <= '0;
      rx_q           <= '0;
      palabra_ref_q  <= '0;
      sindrome_q     <= '0;
      tipo_error_q   <= '0;
      dato_q         <= '0;
      coincide_q     <= 1'b0;
      valido_q       <= 1'b0;
      mostrando_q    <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      sync_cargar_q  <= sync_cargar_d;
      sync_evaluar_q <= sync_evaluar_d;
      prev_cargar_q  <= sync_cargar_q[N_SYNC-1];
      prev_evaluar_q <= sync_evaluar_q[N_SYNC-1];
      cnt_q          <= cnt_d;
      rx_q           <= rx_d;
      palabra_ref_q  <= palabra_ref_d;
      sindrome_q     <= sindrome_d;
      tipo_error_q   <= tipo_error_d;
      dato_q         <= dato_d;
      coincide_q     <= coincide_d;
      valido_q       <= valido_d;
      mostrando_q    <= mostrando_d;
    end
  end

  assign palabra_ref      = palabra_ref_q;
  assign sindrome         = sindrome_q;
  assign tipo_error       = tipo_error_q;
  assign dato_corregido   = dato_q;
  assign coincide         = coincide_q;
  assign resultado_valido = valido_q;
  assign mostrando        = mostrando_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_hamming.sv
// ============================================================================
// Module   : tb_controlador_hamming
// Summary  : Directed bench for controlador_hamming with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_hamming;

  localparam int T = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] conmutador_4 = '0;
  logic [7:0] conmutador_8 = '0;
  logic       btn_cargar = 1'b0;
  logic       btn_evaluar = 1'b0;
  logic [3:0] palabra_ref, sindrome, dato_corregido;
  logic [1:0] tipo_error;
  logic       coincide, resultado_valido, mostrando;

  typedef struct packed {
    logic [3:0] sin;
    logic [1:0] tipo;
    logic [3:0] dato;
    logic       coin;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  controlador_hamming #(.T_MUESTRA(T), .N_SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .conmutador_4(conmutador_4), .conmutador_8(conmutador_8),
    .btn_cargar(btn_cargar), .btn_evaluar(btn_evaluar),
    .palabra_ref(palabra_ref), .sindrome(sindrome), .tipo_error(tipo_error),
    .dato_corregido(dato_corregido), .coincide(coincide),
    .resultado_valido(resultado_valido), .mostrando(mostrando)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder: data {w0,w1,w2,w3} placed at Hamming positions 3,5,6,7.
  function automatic logic [7:0] encode(input logic [3:0] w);
    logic [7:0] c;
    c = '0;
    c[2] = w[3]; c[4] = w[2]; c[5] = w[1]; c[6] = w[0];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Reference decoder: syndrome as XOR of the positions of set bits.
  function automatic exp_t model(input logic [7:0] cw, input logic [3:0] r);
    exp_t       e;
    logic [2:0] s;
    logic [7:0] c;
    logic       gp;
    s = '0;
    c = cw;
    gp = ^cw;
    for (int p = 1; p <= 7; p++)
      if (cw[p-1]) s = s ^ 3'(p);
    e.sin  = {gp, s};
    e.tipo = gp ? 2'b01 : ((s != 3'd0) ? 2'b10 : 2'b00);
`ifdef CORRECCION_EN
    if (gp && s != 3'd0) c[s-3'd1] = ~c[s-3'd1];
`endif
    e.dato = {c[2], c[4], c[5], c[6]};
    e.coin = (e.dato == r);
    return e;
  endfunction

  // Scoreboard consumer: each result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resultado_valido) begin
      if (sb.size() == 0) begin
        check("unexpected resultado_valido", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sindrome", 32'(sindrome), 32'(e.sin));
        check("tipo_error", 32'(tipo_error), 32'(e.tipo));
        check("dato_corregido", 32'(dato_corregido), 32'(e.dato));
        check("coincide", 32'(coincide), 32'(e.coin));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cargar(input logic [3:0] v);
    conmutador_4 = v;
    btn_cargar = 1'b1;
    ticks(2);
    btn_cargar = 1'b0;
    ticks(6);
  endtask

  task automatic eval_step(input string tag, input logic [7:0] cw, input exp_t e, input int hold);
    int lat;
    int on;
    lat = -1;
    on = 0;
    conmutador_8 = cw;
    btn_evaluar = 1'b1;
    sb.push_back(e);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == hold) btn_evaluar = 1'b0;
      if (resultado_valido && lat < 0) lat = c;
      if (mostrando) on++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " mostrando cycles"}, 32'(on), 32'(T));
    check({tag, " sindrome held"}, 32'(sindrome), 32'(e.sin));
  endtask

  initial begin
    exp_t e;
    logic [7:0] cw;
    int waited;

    #1;
    check("reset outputs", 32'({palabra_ref, sindrome, tipo_error, dato_corregido,
                                coincide, resultado_valido, mostrando}), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Evaluate before any reference load is ignored.
    conmutador_8 = 8'h66;
    btn_evaluar = 1'b1;
    ticks(2);
    btn_evaluar = 1'b0;
    ticks(10);
    check("evaluar ignored in ESPERA_REF", 32'(mostrando), 32'd0);

    // Load reference with exact latency.
    conmutador_4 = 4'b1011;
    btn_cargar = 1'b1;
    ticks(2);
    check("palabra_ref before capture edge", 32'(palabra_ref), 32'd0);
    btn_cargar = 1'b0;
    ticks(1);
    check("palabra_ref after cargar", 32'(palabra_ref), 32'hB);
    check("results zero after cargar", 32'({sindrome, tipo_error, dato_corregido, coincide}), 32'd0);
    ticks(5);

    cw = encode(4'b1011);
    check("encoded clean word", 32'(cw), 32'h66);
    eval_step("clean", cw, '{sin: 4'b0000, tipo: 2'b00, dato: 4'b1011, coin: 1'b1}, 2);

`ifdef CORRECCION_EN
    e = '{sin: 4'b1101, tipo: 2'b01, dato: 4'b1011, coin: 1'b1};
`else
    e = '{sin: 4'b1101, tipo: 2'b01, dato: 4'b1111, coin: 1'b0};
`endif
    eval_step("w1 flip", cw ^ 8'h10, e, 2);
    eval_step("double 0,5", cw ^ 8'h21, '{sin: 4'b0111, tipo: 2'b10, dato: 4'b1001, coin: 1'b0}, 2);
    eval_step("g0 flip", cw ^ 8'h80, '{sin: 4'b1000, tipo: 2'b01, dato: 4'b1011, coin: 1'b1}, 2);
    eval_step("held 20 cycles", cw, '{sin: 4'b0000, tipo: 2'b00, dato: 4'b1011, coin: 1'b1}, 20);

    for (int i = 0; i < 3; i++) begin
      cw = 8'($urandom);
      eval_step("random", cw, model(cw, 4'b1011), 2);
    end

    // Both buttons together: only the reference reload happens.
    conmutador_4 = 4'b0101;
    conmutador_8 = 8'h66;
    btn_cargar = 1'b1;
    btn_evaluar = 1'b1;
    ticks(2);
    btn_cargar = 1'b0;
    btn_evaluar = 1'b0;
    ticks(10);
    check("both buttons palabra_ref", 32'(palabra_ref), 32'h5);
    check("both buttons mostrando", 32'(mostrando), 32'd0);
    cargar(4'b1011);

    // Reset asserted during MUESTRA.
    conmutador_8 = 8'h66;
    btn_evaluar = 1'b1;
    sb.push_back('{sin: 4'b0000, tipo: 2'b00, dato: 4'b1011, coin: 1'b1});
    waited = 0;
    while (!mostrando && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    btn_evaluar = 1'b0;
    check("reached MUESTRA", 32'(mostrando), 32'd1);
    ticks(1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({palabra_ref, sindrome, tipo_error, dato_corregido,
                                      coincide, resultado_valido, mostrando}), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    conmutador_8 = 8'h66;
    btn_evaluar = 1'b1;
    ticks(2);
    btn_evaluar = 1'b0;
    ticks(10);
    check("evaluar ignored after reset", 32'(mostrando), 32'd0);
    check("palabra_ref after reset", 32'(palabra_ref), 32'd0);

    cargar(4'b1011);
    eval_step("after reset", 8'h66, '{sin: 4'b0000, tipo: 2'b00, dato: 4'b1011, coin: 1'b1}, 2);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
